// File: rtl/clock_set_ctrl_if.sv
// rtl/clock_set_ctrl_if.sv - button, counter-chain and edit-register bundle for clock_set_ctrl
//
// Purpose: groups the push-button inputs, the live counts from the
//          sec/min/hour chain and everything clock_set_ctrl drives back
//          into that chain.
// Signals:
//   mode_btn, inc_btn         button levels (synchronised, debounced)
//   count_sec/min/hour [5:0]  live time from the counter chain
//   enable                    one-cycle seconds tick
//   load                      one-cycle load strobe
//   data_sec/min/hour [5:0]   edit registers
//   setting1/2/3              editing sec / min / hour
//   set_active                any edit state
// Modports: slave = clock_set_ctrl side, master = buttons/chain side.

interface clock_set_ctrl_if;
  logic       mode_btn;
  logic       inc_btn;
  logic [5:0] count_sec;
  logic [5:0] count_min;
  logic [5:0] count_hour;
  logic       enable;
  logic       load;
  logic [5:0] data_sec;
  logic [5:0] data_min;
  logic [5:0] data_hour;
  logic       setting1;
  logic       setting2;
  logic       setting3;
  logic       set_active;

  modport slave (
    input  mode_btn, inc_btn, count_sec, count_min, count_hour,
    output enable, load, data_sec, data_min, data_hour,
           setting1, setting2, setting3, set_active
  );

  modport master (
    output mode_btn, inc_btn, count_sec, count_min, count_hour,
    input  enable, load, data_sec, data_min, data_hour,
           setting1, setting2, setting3, set_active
  );
endinterface

// File: rtl/clock_set_ctrl.sv
// rtl/clock_set_ctrl.sv - time-set sequencer and 1 Hz tick generator for the sec/min/hour chain
//
// Purpose: turns the mode/inc buttons into a RUN -> SET_HOUR -> SET_MIN ->
//          SET_SEC -> RUN sequence, keeps per-field edit registers, pulses
//          load on return to RUN and generates the seconds enable tick in RUN.
// Ports:
//   clock  system clock, rising edge
//   reset  asynchronous, active-high; clears all state
//   bus    clock_set_ctrl_if.slave (buttons, live counts, chain controls)
// Parameters: TICK_DIV, REPEAT_DLY, REPEAT_PER (clock cycles).
// Macro: AUTO_REPEAT_EN builds the held-inc auto-repeat counter; without it
//        each rising edge of inc_btn gives exactly one increment.

module clock_set_ctrl #(
  parameter int TICK_DIV   = 50_000_000,
  parameter int REPEAT_DLY = 25_000_000,
  parameter int REPEAT_PER = 5_000_000
) (
  input  logic              clock,
  input  logic              reset,
  clock_set_ctrl_if.slave   bus
);

  localparam int DW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;

  typedef enum logic [1:0] {RUN, SET_HOUR, SET_MIN, SET_SEC} state_t;

  state_t        state;
  logic [DW-1:0] divider;
  logic          mode_prev;
  logic          inc_prev;
  logic          mode_press;
  logic          inc_press;
  logic          inc_fire;
  logic          enable_r;
  logic          load_r;
  logic [5:0]    data_sec_r;
  logic [5:0]    data_min_r;
  logic [5:0]    data_hour_r;
  logic          setting1_r;
  logic          setting2_r;
  logic          setting3_r;
  logic          set_active_r;

  assign mode_press = bus.mode_btn & ~mode_prev;
  assign inc_press  = bus.inc_btn  & ~inc_prev;

  // Anything at or above the limit (e.g. a captured 63) wraps to 0.
  function automatic logic [5:0] bump(input logic [5:0] v, input logic [5:0] lim);
    return (v >= lim) ? 6'd0 : v + 6'd1;
  endfunction

`ifdef AUTO_REPEAT_EN
  localparam int RMAX = (REPEAT_DLY > REPEAT_PER) ? REPEAT_DLY : REPEAT_PER;
  localparam int RW   = (RMAX > 2) ? $clog2(RMAX) : 1;

  logic [RW-1:0] rep_cnt;
  logic          rep_phase;  // 0: waiting out REPEAT_DLY, 1: repeating every REPEAT_PER

  always_comb begin
    inc_fire = 1'b0;
    if (inc_press) begin
      inc_fire = 1'b1;
    end else if (bus.inc_btn && inc_prev) begin
      if (!rep_phase && rep_cnt == RW'(REPEAT_DLY - 1))
        inc_fire = 1'b1;
      else if (rep_phase && rep_cnt == RW'(REPEAT_PER - 1))
        inc_fire = 1'b1;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      rep_cnt   <= '0;
      rep_phase <= 1'b0;
    end else if (state == RUN || !bus.inc_btn || mode_press || inc_press) begin
      rep_cnt   <= '0;
      rep_phase <= 1'b0;
    end else if (inc_fire) begin
      rep_cnt   <= '0;
      rep_phase <= 1'b1;
    end else begin
      rep_cnt   <= rep_cnt + RW'(1);
    end
  end
`else
  always_comb begin
    inc_fire = inc_press;
  end
`endif

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state        <= RUN;
      divider      <= '0;
      mode_prev    <= 1'b0;
      inc_prev     <= 1'b0;
      enable_r     <= 1'b0;
      load_r       <= 1'b0;
      data_sec_r   <= 6'd0;
      data_min_r   <= 6'd0;
      data_hour_r  <= 6'd0;
      setting1_r   <= 1'b0;
      setting2_r   <= 1'b0;
      setting3_r   <= 1'b0;
      set_active_r <= 1'b0;
    end else begin
      mode_prev <= bus.mode_btn;
      inc_prev  <= bus.inc_btn;
      enable_r  <= 1'b0;
      load_r    <= 1'b0;
      case (state)
        RUN: begin
          if (mode_press) begin
            state        <= SET_HOUR;
            divider      <= '0;
            data_hour_r  <= bus.count_hour;
            data_min_r   <= bus.count_min;
            data_sec_r   <= bus.count_sec;
            setting3_r   <= 1'b1;
            set_active_r <= 1'b1;
          end else if (divider == DW'(TICK_DIV - 1)) begin
            enable_r <= 1'b1;
            divider  <= '0;
          end else begin
            divider  <= divider + DW'(1);
          end
        end
        SET_HOUR: begin
          divider <= '0;
          if (mode_press) begin
            state      <= SET_MIN;
            setting3_r <= 1'b0;
            setting2_r <= 1'b1;
          end else if (inc_fire) begin
            data_hour_r <= bump(data_hour_r, 6'd23);
          end
        end
        SET_MIN: begin
          divider <= '0;
          if (mode_press) begin
            state      <= SET_SEC;
            setting2_r <= 1'b0;
            setting1_r <= 1'b1;
          end else if (inc_fire) begin
            data_min_r <= bump(data_min_r, 6'd59);
          end
        end
        default: begin  // SET_SEC
          divider <= '0;
          if (mode_press) begin
            // load lands on the first RUN cycle while divider is still 0,
            // so the next tick is TICK_DIV cycles later.
            state        <= RUN;
            load_r       <= 1'b1;
            setting1_r   <= 1'b0;
            set_active_r <= 1'b0;
          end else if (inc_fire) begin
            data_sec_r <= bump(data_sec_r, 6'd59);
          end
        end
      endcase
    end
  end

  assign bus.enable     = enable_r;
  assign bus.load       = load_r;
  assign bus.data_sec   = data_sec_r;
  assign bus.data_min   = data_min_r;
  assign bus.data_hour  = data_hour_r;
  assign bus.setting1   = setting1_r;
  assign bus.setting2   = setting2_r;
  assign bus.setting3   = setting3_r;
  assign bus.set_active = set_active_r;

endmodule
